// File: rtl/tour_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tour_cmd_seq
// Purpose  : Shares cmd_proc between the UART command path and the Knight's
//            Tour replay. While idle, UART commands pass straight through. After
//            tour_go, each solved L-move is issued as a vertical leg followed by
//            a horizontal leg with fanfare.
// Revision : 1.0 - initial release
// ============================================================================
module tour_cmd_seq #(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tour_go_i,
    input  logic [7:0]       move_i,
    output logic [IDX_W-1:0] mv_indx_o,
    input  logic [15:0]      cmd_UART_i,
    input  logic             cmd_rdy_UART_i,
    output logic             clr_cmd_rdy_UART_o,
    output logic [15:0]      cmd_o,
    output logic             cmd_rdy_o,
    input  logic             clr_cmd_rdy_i,
    input  logic             send_resp_i,
    output logic [7:0]       resp_o,
    output logic             tour_active_o
);

    localparam logic [3:0]       c_OP_MOVE   = 4'h2;
    localparam logic [3:0]       c_OP_FANF   = 4'h3;
    localparam logic [7:0]       c_HDG_N     = 8'h00;
    localparam logic [7:0]       c_HDG_W     = 8'h3F;
    localparam logic [7:0]       c_HDG_S     = 8'h7F;
    localparam logic [7:0]       c_HDG_E     = 8'hBF;
    localparam logic [7:0]       c_RESP_DONE = 8'hA5;
    localparam logic [7:0]       c_RESP_MORE = 8'h5A;
    localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(NUM_MOVES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        VERT   = 3'd2,
        WAIT_V = 3'd3,
        HORZ   = 3'd4,
        WAIT_H = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   mv_indx_q, mv_indx_d;
    logic [7:0]         mv_reg_q, mv_reg_d;
    logic [15:0]        cmd_q, cmd_d;
    logic               w_last;

    // Vertical leg of a one-hot knight move; the lowest set bit wins.
    function automatic logic [15:0] f_vert_cmd(input logic [7:0] m);
        logic [15:0] c;
        c = 16'h0000;
        casez (m)
            8'b???????1: c = {c_OP_MOVE, c_HDG_N, 4'd2};
            8'b??????10: c = {c_OP_MOVE, c_HDG_N, 4'd2};
            8'b?????100: c = {c_OP_MOVE, c_HDG_N, 4'd1};
            8'b????1000: c = {c_OP_MOVE, c_HDG_S, 4'd1};
            8'b???10000: c = {c_OP_MOVE, c_HDG_S, 4'd2};
            8'b??100000: c = {c_OP_MOVE, c_HDG_S, 4'd2};
            8'b?1000000: c = {c_OP_MOVE, c_HDG_S, 4'd1};
            8'b10000000: c = {c_OP_MOVE, c_HDG_N, 4'd1};
            default:     c = 16'h0000;
        endcase
        return c;
    endfunction

    // Horizontal leg (with fanfare) of a one-hot knight move; lowest bit wins.
    function automatic logic [15:0] f_horz_cmd(input logic [7:0] m);
        logic [15:0] c;
        c = 16'h0000;
        casez (m)
            8'b???????1: c = {c_OP_FANF, c_HDG_E, 4'd1};
            8'b??????10: c = {c_OP_FANF, c_HDG_W, 4'd1};
            8'b?????100: c = {c_OP_FANF, c_HDG_W, 4'd2};
            8'b????1000: c = {c_OP_FANF, c_HDG_W, 4'd2};
            8'b???10000: c = {c_OP_FANF, c_HDG_W, 4'd1};
            8'b??100000: c = {c_OP_FANF, c_HDG_E, 4'd1};
            8'b?1000000: c = {c_OP_FANF, c_HDG_E, 4'd2};
            8'b10000000: c = {c_OP_FANF, c_HDG_E, 4'd2};
            default:     c = 16'h0000;
        endcase
        return c;
    endfunction

    assign w_last    = (mv_indx_q == c_LAST_IDX);
    assign mv_indx_o = mv_indx_q;

    // State, move index, latched move and registered tour command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mv_indx_q <= '0;
            mv_reg_q  <= 8'h00;
            cmd_q     <= 16'h0000;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
            mv_reg_q  <= mv_reg_d;
            cmd_q     <= cmd_d;
        end
    end

    // Next-state logic and outputs; IDLE forwards the UART path untouched.
    always_comb begin
        state_d            = state_q;
        mv_indx_d          = mv_indx_q;
        mv_reg_d           = mv_reg_q;
        cmd_d              = cmd_q;
        cmd_o              = cmd_q;
        cmd_rdy_o          = 1'b0;
        clr_cmd_rdy_UART_o = 1'b0;
        resp_o             = c_RESP_MORE;
        tour_active_o      = 1'b1;

        case (state_q)
            IDLE: begin
                cmd_o              = cmd_UART_i;
                cmd_rdy_o          = cmd_rdy_UART_i;
                clr_cmd_rdy_UART_o = clr_cmd_rdy_i;
                resp_o             = c_RESP_DONE;
                tour_active_o      = 1'b0;
                if (tour_go_i) begin
                    mv_indx_d = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                mv_reg_d = move_i;
                if (move_i == 8'h00) begin
                    // Empty move slot: nothing to replay.
                    state_d = IDLE;
                end else begin
                    cmd_d   = f_vert_cmd(move_i);
                    state_d = VERT;
                end
            end
            VERT: begin
                cmd_rdy_o = 1'b1;
                if (clr_cmd_rdy_i) begin
                    state_d = WAIT_V;
                end
            end
            WAIT_V: begin
                if (send_resp_i) begin
                    cmd_d   = f_horz_cmd(mv_reg_q);
                    state_d = HORZ;
                end
            end
            HORZ: begin
                cmd_rdy_o = 1'b1;
                if (clr_cmd_rdy_i) begin
                    state_d = WAIT_H;
                end
            end
            WAIT_H: begin
                resp_o = w_last ? c_RESP_DONE : c_RESP_MORE;
                if (send_resp_i) begin
                    if (w_last) begin
                        state_d = IDLE;
                    end else begin
                        mv_indx_d = mv_indx_q + IDX_W'(1);
                        state_d   = LOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tour_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tour_cmd_seq
// Purpose  : Self-checking bench for tour_cmd_seq: table of idle passthrough
//            vectors, scoreboard-driven tour replays, reset and abort cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tour_cmd_seq;

    localparam int NUM_MOVES = 24;
    localparam int IDX_W     = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             tour_go;
    logic [7:0]       move;
    logic [IDX_W-1:0] mv_indx;
    logic [15:0]      cmd_UART;
    logic             cmd_rdy_UART;
    logic             clr_cmd_rdy_UART;
    logic [15:0]      cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy;
    logic             send_resp;
    logic [7:0]       resp;
    logic             tour_active;

    logic [7:0] mem [0:31];
    assign move = mem[mv_indx];

    always #5 clk = ~clk;

    tour_cmd_seq #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .tour_go_i          (tour_go),
        .move_i             (move),
        .mv_indx_o          (mv_indx),
        .cmd_UART_i         (cmd_UART),
        .cmd_rdy_UART_i     (cmd_rdy_UART),
        .clr_cmd_rdy_UART_o (clr_cmd_rdy_UART),
        .cmd_o              (cmd),
        .cmd_rdy_o          (cmd_rdy),
        .clr_cmd_rdy_i      (clr_cmd_rdy),
        .send_resp_i        (send_resp),
        .resp_o             (resp),
        .tour_active_o      (tour_active)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Knight displacement per move bit (+y north, +x east).
    int dxt [8] = '{ 1, -1, -2, -2, -1,  1,  2, 2};
    int dyt [8] = '{ 2,  2,  1, -1, -2, -2, -1, 1};

    typedef struct {
        logic [15:0] cmd;
        logic [7:0]  resp;
        int          lat;
    } exp_t;
    exp_t sb[$];

    // Predict every leg of the tour currently held in mem.
    task automatic push_tour();
        logic [7:0] m;
        int b, dx, dy, adx, ady;
        exp_t e;
        for (int i = 0; i < NUM_MOVES; i++) begin
            m = mem[i];
            b = -1;
            for (int k = 7; k >= 0; k--) if (m[k]) b = k;
            if (b < 0) break;
            dx  = dxt[b];
            dy  = dyt[b];
            adx = (dx < 0) ? -dx : dx;
            ady = (dy < 0) ? -dy : dy;
            e.cmd  = {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'(ady)};
            e.resp = 8'h5A;
            e.lat  = 2;
            sb.push_back(e);
            e.cmd  = {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'(adx)};
            e.resp = (i == NUM_MOVES - 1) ? 8'hA5 : 8'h5A;
            e.lat  = 1;
            sb.push_back(e);
        end
    endtask

    // Replay a tour; optionally with a pending UART command, a stray tour_go,
    // or a reset applied when leg rst_leg is presented.
    task automatic run_tour(input bit uart_pend, input bit extra_go, input int rst_leg);
        exp_t e;
        int   lat, leg, hold;
        bit   found;
        push_tour();
        leg = 0;
        @(negedge clk);
        tour_go = 1'b1;
        if (uart_pend) begin
            cmd_UART     = 16'h2055;
            cmd_rdy_UART = 1'b1;
        end
        while (sb.size() > 0) begin
            e     = sb.pop_front();
            lat   = 0;
            found = 1'b0;
            while (lat < 8 && !found) begin
                @(negedge clk);
                lat++;
                found     = cmd_rdy;
                tour_go   = 1'b0;
                send_resp = 1'b0;
            end
            chk("leg_latency", lat, e.lat);
            if (!found) begin
                sb.delete();
                break;
            end
            chk("leg_cmd", cmd, e.cmd);
            if (leg == rst_leg) begin
                chk("rst_pre_indx", 32'(mv_indx), 32'(leg / 2));
                cmd_UART     = 16'h2ABC;
                cmd_rdy_UART = 1'b1;
                rst          = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("rst_active", tour_active, 0);
                chk("rst_indx", 32'(mv_indx), 0);
                chk("rst_resp", resp, 8'hA5);
                chk("rst_rdy_follow", cmd_rdy, 1);
                chk("rst_cmd_follow", cmd, 16'h2ABC);
                cmd_rdy_UART = 1'b0;
                sb.delete();
                return;
            end
            hold = int'($urandom_range(0, 2));
            repeat (hold) begin
                @(negedge clk);
                chk("cmd_hold", cmd, e.cmd);
                chk("rdy_hold", cmd_rdy, 1);
            end
            clr_cmd_rdy = 1'b1;
            if (extra_go && leg == 5) tour_go = 1'b1;
            #1;
            chk("clr_uart_blocked", clr_cmd_rdy_UART, 0);
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
            tour_go     = 1'b0;
            #1;
            chk("rdy_drop", cmd_rdy, 0);
            chk("active_mid", tour_active, 1);
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
            send_resp = 1'b1;
            #1;
            chk("leg_resp", resp, e.resp);
            leg++;
        end
        @(negedge clk);
        send_resp = 1'b0;
        tour_go   = 1'b0;
        #1;
        chk("end_active", tour_active, 0);
        chk("end_indx", 32'(mv_indx), NUM_MOVES - 1);
        chk("end_resp", resp, 8'hA5);
        if (uart_pend) begin
            chk("pending_cmd", cmd, 16'h2055);
            chk("pending_rdy", cmd_rdy, 1);
            cmd_rdy_UART = 1'b0;
        end
    endtask

    typedef struct {
        logic [15:0] cu;
        logic        ru;
        logic        cl;
        logic        sr;
        logic [15:0] e_cmd;
        logic        e_rdy;
        logic        e_clru;
        logic [7:0]  e_resp;
        logic        e_act;
    } vec_t;
    vec_t vt [6];

    initial begin
        vt[0] = '{16'h2001, 1'b1, 1'b0, 1'b0, 16'h2001, 1'b1, 1'b0, 8'hA5, 1'b0};
        vt[1] = '{16'h2001, 1'b1, 1'b1, 1'b0, 16'h2001, 1'b1, 1'b1, 8'hA5, 1'b0};
        vt[2] = '{16'h2001, 1'b0, 1'b0, 1'b0, 16'h2001, 1'b0, 1'b0, 8'hA5, 1'b0};
        vt[3] = '{16'hBEEF, 1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 8'hA5, 1'b0};
        vt[4] = '{16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'hA5, 1'b0};
        vt[5] = '{16'h3BF1, 1'b1, 1'b0, 1'b1, 16'h3BF1, 1'b1, 1'b0, 8'hA5, 1'b0};

        for (int i = 0; i < 32; i++) mem[i] = 8'(8'h01 << $urandom_range(0, 7));
        mem[0] = 8'h01;
        mem[3] = 8'h0C;

        rst          = 1'b1;
        tour_go      = 1'b0;
        cmd_UART     = 16'h0000;
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_indx", 32'(mv_indx), 0);
        chk("reset_active", tour_active, 0);
        chk("reset_resp", resp, 8'hA5);
        chk("reset_rdy", cmd_rdy, 0);
        rst = 1'b0;

        // Idle passthrough table
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmd_UART     = vt[i].cu;
            cmd_rdy_UART = vt[i].ru;
            clr_cmd_rdy  = vt[i].cl;
            send_resp    = vt[i].sr;
            #1;
            chk("idle_cmd", cmd, vt[i].e_cmd);
            chk("idle_rdy", cmd_rdy, vt[i].e_rdy);
            chk("idle_clr_uart", clr_cmd_rdy_UART, vt[i].e_clru);
            chk("idle_resp", resp, vt[i].e_resp);
            chk("idle_active", tour_active, vt[i].e_act);
        end
        @(negedge clk);
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        @(negedge clk);
        chk("idle_stays", tour_active, 0);

        // Tour A: first move north 2 / east 1, includes a multi-bit entry
        run_tour(1'b0, 1'b0, -1);

        // Tour B: first move south 1 / west 2, pending UART and stray tour_go
        mem[0] = 8'h08;
        run_tour(1'b1, 1'b1, -1);

        // Tour C: reset while HORZ is presented at index 7
        mem[0] = 8'h80;
        run_tour(1'b0, 1'b0, 15);

        // Empty move slot aborts with no command
        mem[0] = 8'h00;
        @(negedge clk);
        tour_go = 1'b1;
        @(negedge clk);
        tour_go = 1'b0;
        #1;
        chk("abort_load_active", tour_active, 1);
        chk("abort_load_rdy", cmd_rdy, 0);
        repeat (4) begin
            @(negedge clk);
            chk("abort_rdy", cmd_rdy, 0);
            chk("abort_active", tour_active, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
Command sequencer that shares cmd_proc between the UART command path (UART_wrapper) and the Knight's Tour solution. When idle, it passes UART commands straight through. After tour_go, it walks the solved move list. Each knight L-move is split into two cmd_proc move commands: a vertical leg, then a horizontal leg with fanfare. It chooses the response byte the UART returns after each leg.

Parameters:
NUM_MOVES, 24, number of moves in the tour (5x5 board: 25 squares, 24 moves)
IDX_W, 5, width of mv_indx

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tour_go  in  1  pulse from cmd_proc; start replaying the tour
move  in  8  one-hot move read from the TourLogic move memory at mv_indx
mv_indx  out  IDX_W  move memory read index
cmd_UART  in  16  command from UART_wrapper
cmd_rdy_UART  in  1  UART command valid
clr_cmd_rdy_UART  out  1  knock-down to UART_wrapper
cmd  out  16  command presented to cmd_proc
cmd_rdy  out  1  command valid to cmd_proc
clr_cmd_rdy  in  1  cmd_proc accepted cmd
send_resp  in  1  cmd_proc finished the command
resp  out  8  response byte to UART_wrapper (8'hA5 = done, 8'h5A = tour leg done, more to follow)
tour_active  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, LOAD, VERT, WAIT_V, HORZ, WAIT_H. Reset leaves the block in IDLE with mv_indx=0 and mv_reg=0.
- Output values in IDLE (including reset):
  - cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy.
  - resp=8'hA5, tour_active=0.
- Output values outside IDLE:
  - cmd_rdy_UART is not forwarded; clr_cmd_rdy_UART=0.
  - Any UART command arriving now stays pending in UART_wrapper and is serviced after return to IDLE.
- IDLE: on tour_go, clear mv_indx to 0 and go to LOAD. tour_go in any other state is ignored.
- LOAD (one cycle):
  - Latch move into mv_reg and go to VERT.
  - If move==0: abort to IDLE with no command issued.
  - If more than one bit is set, the lowest set bit wins.
- Move decode (dx, dy; +y = north, +x = east):
  - bit0 (+1,+2), bit1 (-1,+2), bit2 (-2,+1), bit3 (-2,-1)
  - bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
  - Opcode 4'h2 = move; 4'h3 = move with fanfare.
  - Heading: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- VERT: cmd={4'h2, dy>0 ? N : S, |dy|}, cmd_rdy=1. On clr_cmd_rdy go to WAIT_V; cmd_rdy drops the following cycle.
- WAIT_V: cmd_rdy=0, resp=8'h5A. On send_resp go to HORZ.
- HORZ: cmd={4'h3, dx>0 ? E : W, |dx|}, cmd_rdy=1. On clr_cmd_rdy go to WAIT_H.
- WAIT_H: resp = 8'hA5 if mv_indx==NUM_MOVES-1, else 8'h5A. On send_resp:
  - If last move: go to IDLE.
  - Otherwise: increment mv_indx and go to LOAD.
- resp is combinational from state/index. It must be valid in the same cycle send_resp is high, because UART_wrapper samples it then.
- cmd is registered from mv_reg and stays stable for the whole of VERT and HORZ.
- Latency: tour_go at cycle t gives cmd_rdy=1 at t+2. send_resp in WAIT_H gives the next VERT cmd_rdy 2 cycles later.
- mv_indx never exceeds NUM_MOVES-1 and does not wrap.
- clr_cmd_rdy or send_resp arriving in a state that does not expect it is ignored.
- rst asserted mid-tour: next cycle the block is in IDLE, mv_indx=0, cmd_rdy follows cmd_rdy_UART.

Test Plan:
1. Reset, then drive cmd_UART=16'h2001, cmd_rdy_UART=1 -> cmd=16'h2001, cmd_rdy=1, resp=8'hA5; pulse clr_cmd_rdy -> clr_cmd_rdy_UART pulses in the same cycle.
2. tour_go with move[0]=8'h01 -> cmd=16'h2002 (north 2), cmd_rdy 2 cycles after tour_go; on clr + send_resp, resp=8'h5A; then cmd=16'h3BF1 (east 1).
3. Index 0 holds move 8'h08 -> VERT cmd=16'h27F1 (south 1), HORZ cmd=16'h33F2 (west 2 with fanfare).
4. Full 24-move tour with scripted clr_cmd_rdy/send_resp -> 48 commands issued; resp=8'h5A on the first 47 send_resp and 8'hA5 on the 48th; block ends in IDLE, tour_active=0, mv_indx=23.
5. cmd_rdy_UART=1 mid-tour, plus an extra tour_go -> no UART passthrough and tour unaffected; after the tour ends, the pending UART command appears on cmd.
6. rst in HORZ at index 7 -> next cycle state IDLE, mv_indx=0, resp=8'hA5; separately, move=8'h00 in LOAD -> abort to IDLE with no cmd_rdy pulse.
